stream_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that merges NUM_REQ ready/valid input streams onto one ready/valid output port. Once a requester is granted, it holds the output until it transfers a beat flagged end-of-packet; packets are never interleaved. The output is fully registered through a two-entry skid stage, so no combinational path runs from `ready_o` to any `ready_i` bit. It sits in front of the shared storage write pipeline, where several producers contend for one stream.

---
 rtl/stream_rr_arbiter_pkg.sv | 46 ++++
 rtl/stream_rr_arbiter_if.sv | 27 ++
 rtl/stream_rr_arbiter_skid_stage.sv | 67 ++++++
 rtl/stream_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and the round-robin search used by the packet-aware stream arbiter.
package stream_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Walk ptr, ptr+1, ... and wrap at num_req-1, not at a power of two.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 num_req);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    cand      = ptr;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) begin
        if (!res.found && valid[cand]) begin
          res.found = 1'b1;
          res.idx   = cand;
        end else begin
          res.found = res.found;
        end
        if (int'(cand) == num_req - 1) begin
          cand = {IDX_W{1'b0}};
        end else begin
          cand = cand + IDX_W'(1);
        end
      end else begin
        cand = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the requester-side and downstream ready/valid signals of the arbiter.
interface stream_rr_arbiter_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
);
  logic [NUM_REQ-1:0]       valid_i;
  logic [NUM_REQ*WIDTH-1:0] dat_i;
  logic [NUM_REQ-1:0]       eop_i;
  logic [NUM_REQ-1:0]       ready_i;
  logic                     valid_o;
  logic [WIDTH-1:0]         dat_o;
  logic                     eop_o;
  logic [PTR_W-1:0]         src_o;
  logic                     ready_o;
  logic [NUM_REQ-1:0]       gnt_o;

  modport slave (
    input  valid_i, dat_i, eop_i, ready_o,
    output ready_i, valid_o, dat_o, eop_o, src_o, gnt_o
  );

  modport master (
    output valid_i, dat_i, eop_i, ready_o,
    input  ready_i, valid_o, dat_o, eop_o, src_o, gnt_o
  );
endinterface

// File: rtl/stream_rr_arbiter_skid_stage.sv
// Two-entry output skid buffer; stage_rdy is registered so upstream ready never sees ready_o.
module arb_skid_stage #(
  parameter int unsigned DW = 19
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          in_vld_i,
  input  logic [DW-1:0] in_dat_i,
  output logic          stage_rdy_o,
  output logic          out_vld_o,
  output logic [DW-1:0] out_dat_o,
  input  logic          out_rdy_i
);

  logic          main_vld_q, main_vld_d, bak_vld_q, bak_vld_d, stage_rdy_q;
  logic [DW-1:0] main_q, main_d, bak_q, bak_d;

  // Next state of both entries; a full backup implies a full main and no new input.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    bak_vld_d  = bak_vld_q;
    bak_d      = bak_q;
    if (bak_vld_q) begin
      if (out_rdy_i) begin
        main_d    = bak_q;
        bak_vld_d = 1'b0;
      end else begin
        bak_vld_d = 1'b1;
      end
    end else if (in_vld_i) begin
      if (!main_vld_q || out_rdy_i) begin
        main_vld_d = 1'b1;
        main_d     = in_dat_i;
      end else begin
        bak_vld_d = 1'b1;
        bak_d     = in_dat_i;
      end
    end else if (out_rdy_i) begin
      main_vld_d = 1'b0;
    end else begin
      main_vld_d = main_vld_q;
    end
  end

  // Entry registers and the registered backup-empty flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_vld_q  <= 1'b0;
      main_q      <= {DW{1'b0}};
      bak_vld_q   <= 1'b0;
      bak_q       <= {DW{1'b0}};
      stage_rdy_q <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      main_q      <= main_d;
      bak_vld_q   <= bak_vld_d;
      bak_q       <= bak_d;
      stage_rdy_q <= !bak_vld_d;
    end
  end

  assign stage_rdy_o = stage_rdy_q;
  assign out_vld_o   = main_vld_q;
  assign out_dat_o   = main_q;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: a granted requester owns the output until its eop beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input logic                 clk,
  input logic                 arst_n,
  stream_rr_arbiter_if.slave  bus
);

  localparam int unsigned DW = WIDTH + PTR_W + 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, ready_s;
  logic [PTR_W-1:0]   gidx_q, gidx_d, ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext_s;
  logic [IDX_W-1:0]   ptr_ext_s;
  pick_t              pick_s;
  logic               sel_vld_s, sel_eop_s, xfer_s, stage_rdy_s;
  logic [WIDTH-1:0]   sel_dat_s;
  logic [DW-1:0]      skid_dat_s;

  // Round-robin search over the live requests starting at ptr.
  always_comb begin
    valid_ext_s                = {MAX_REQ{1'b0}};
    valid_ext_s[NUM_REQ-1:0]   = bus.valid_i;
    ptr_ext_s                  = {IDX_W{1'b0}};
    ptr_ext_s[PTR_W-1:0]       = ptr_q;
    pick_s                     = rr_pick(valid_ext_s, ptr_ext_s, int'(NUM_REQ));
  end

  // One-hot grant mux and the per-requester accept, driven only from registers.
  always_comb begin
    sel_vld_s = 1'b0;
    sel_eop_s = 1'b0;
    sel_dat_s = {WIDTH{1'b0}};
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (gnt_q[k]) begin
        sel_vld_s = sel_vld_s | bus.valid_i[k];
        sel_eop_s = sel_eop_s | bus.eop_i[k];
        sel_dat_s = sel_dat_s | bus.dat_i[k*WIDTH +: WIDTH];
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
    if ((state_q == ARB_LOCKED) && stage_rdy_s) begin
      ready_s = gnt_q;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
    xfer_s = sel_vld_s && (state_q == ARB_LOCKED) && stage_rdy_s;
  end

  // FSM state register together with grant, grant index and priority pointer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= {NUM_REQ{1'b0}};
      gidx_q  <= {PTR_W{1'b0}};
      ptr_q   <= {PTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_q)
      ARB_IDLE: begin
        if (pick_s.found) state_d = ARB_LOCKED;
        else              state_d = ARB_IDLE;
      end
      ARB_LOCKED: begin
        if (xfer_s && sel_eop_s) state_d = ARB_IDLE;
        else                     state_d = ARB_LOCKED;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant and pointer updates; the pointer wraps explicitly at NUM_REQ-1.
  always_comb begin
    gnt_d  = gnt_q;
    gidx_d = gidx_q;
    ptr_d  = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_s.found) begin
          gidx_d = pick_s.idx[PTR_W-1:0];
          for (int k = 0; k < int'(NUM_REQ); k++) begin
            gnt_d[k] = (pick_s.idx == IDX_W'(k));
          end
        end else begin
          gnt_d = {NUM_REQ{1'b0}};
        end
      end
      ARB_LOCKED: begin
        if (xfer_s && sel_eop_s) begin
          gnt_d = {NUM_REQ{1'b0}};
          if (gidx_q == PTR_W'(NUM_REQ - 1)) ptr_d = {PTR_W{1'b0}};
          else                               ptr_d = gidx_q + PTR_W'(1);
        end else begin
          gnt_d = gnt_q;
        end
      end
      default: gnt_d = {NUM_REQ{1'b0}};
    endcase
  end

  arb_skid_stage #(.DW(DW)) u_skid (
    .clk         (clk),
    .arst_n      (arst_n),
    .in_vld_i    (xfer_s),
    .in_dat_i    ({sel_eop_s, gidx_q, sel_dat_s}),
    .stage_rdy_o (stage_rdy_s),
    .out_vld_o   (bus.valid_o),
    .out_dat_o   (skid_dat_s),
    .out_rdy_i   (bus.ready_o)
  );

  assign {bus.eop_o, bus.src_o, bus.dat_o} = skid_dat_s;
  assign bus.ready_i = ready_s;
  assign bus.gnt_o   = gnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (4-requester and 3-requester instances).
module tb_stream_rr_arbiter;
  import stream_arb_pkg::*;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.WIDTH(16), .NUM_REQ(4), .PTR_W(2)) bus4 ();
  stream_rr_arbiter_if #(.WIDTH(16), .NUM_REQ(3), .PTR_W(2)) bus3 ();

  stream_rr_arbiter #(.WIDTH(16), .NUM_REQ(4), .PTR_W(2)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus4.slave));
  stream_rr_arbiter #(.WIDTH(16), .NUM_REQ(3), .PTR_W(2)) dut3 (
    .clk(clk), .arst_n(arst_n), .bus(bus3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req4(input int k, input logic v, input logic [15:0] d, input logic e);
    bus4.valid_i[k]        = v;
    bus4.dat_i[k*16 +: 16] = d;
    bus4.eop_i[k]          = e;
  endtask

  task automatic req3(input int k, input logic v, input logic [15:0] d, input logic e);
    bus3.valid_i[k]        = v;
    bus3.dat_i[k*16 +: 16] = d;
    bus3.eop_i[k]          = e;
  endtask

  initial begin
    bus4.valid_i = 4'b0; bus4.dat_i = 64'h0; bus4.eop_i = 4'b0; bus4.ready_o = 1'b1;
    bus3.valid_i = 3'b0; bus3.dat_i = 48'h0; bus3.eop_i = 3'b0; bus3.ready_o = 1'b1;
    step(); step();
    // reset values
    chk("rst_valid", 32'(bus4.valid_o), 32'd0);
    chk("rst_gnt",   32'(bus4.gnt_o),   32'd0);
    chk("rst_ready", 32'(bus4.ready_i), 32'd0);
    chk("rst_dat",   32'(bus4.dat_o),   32'd0);
    chk("rst_eop",   32'(bus4.eop_o),   32'd0);
    chk("rst_src",   32'(bus4.src_o),   32'd0);
    arst_n = 1'b1;
    step();

    // all four requesters stream single-beat packets
    for (int k = 0; k < 4; k++) req4(k, 1'b1, 16'h1000 + 16'(k), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_gnt",    32'(bus4.gnt_o),   32'(4'b0001 << (i % 4)));
      chk("t1_bubble", 32'(bus4.valid_o), 32'd0);
      step();
      chk("t1_valid",  32'(bus4.valid_o), 32'd1);
      chk("t1_src",    32'(bus4.src_o),   32'(i % 4));
      chk("t1_dat",    32'(bus4.dat_o),   32'(16'h1000 + 16'(i % 4)));
    end
    for (int k = 0; k < 4; k++) req4(k, 1'b0, 16'h0, 1'b0);
    step();

    // requester 2 three-beat packet, requester 0 arrives mid-packet
    req4(2, 1'b1, 16'hA001, 1'b0);
    step();
    chk("t2_gnt",   32'(bus4.gnt_o),   32'h4);
    chk("t2_ready", 32'(bus4.ready_i), 32'h4);
    step();
    req4(2, 1'b1, 16'hA002, 1'b0);
    req4(0, 1'b1, 16'h0B00, 1'b1);
    chk("t2_a1",     32'(bus4.dat_o), 32'hA001);
    chk("t2_a1_src", 32'(bus4.src_o), 32'd2);
    chk("t2_a1_eop", 32'(bus4.eop_o), 32'd0);
    step();
    req4(2, 1'b1, 16'hA003, 1'b1);
    chk("t2_a2",      32'(bus4.dat_o), 32'hA002);
    chk("t2_hold",    32'(bus4.gnt_o), 32'h4);
    step();
    req4(2, 1'b0, 16'h0, 1'b0);
    chk("t2_a3",      32'(bus4.dat_o), 32'hA003);
    chk("t2_a3_eop",  32'(bus4.eop_o), 32'd1);
    chk("t2_gnt_clr", 32'(bus4.gnt_o), 32'd0);
    chk("t2_ptr",     32'(dut.ptr_q),  32'd3);
    step();
    chk("t2_gnt0",    32'(bus4.gnt_o),   32'h1);
    chk("t2_bubble",  32'(bus4.valid_o), 32'd0);
    step();
    req4(0, 1'b0, 16'h0, 1'b0);
    chk("t2_b0",      32'(bus4.dat_o), 32'h0B00);
    chk("t2_b0_src",  32'(bus4.src_o), 32'd0);
    step();
    chk("t2_idle",    32'(bus4.valid_o), 32'd0);

    // requester 1 five-beat packet with a four-cycle downstream stall
    req4(1, 1'b1, 16'hB001, 1'b0);
    step();
    chk("t3_gnt", 32'(bus4.gnt_o), 32'h2);
    step();
    req4(1, 1'b1, 16'hB002, 1'b0);
    bus4.ready_o = 1'b0;
    chk("t3_b1", 32'(bus4.dat_o), 32'hB001);
    step();
    req4(1, 1'b1, 16'hB003, 1'b0);
    chk("t3_full_ready", 32'(bus4.ready_i), 32'd0);
    chk("t3_stall_dat",  32'(bus4.dat_o),   32'hB001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_full_ready", 32'(bus4.ready_i), 32'd0);
      chk("t3_stall_dat",  32'(bus4.dat_o),   32'hB001);
      chk("t3_stall_vld",  32'(bus4.valid_o), 32'd1);
    end
    bus4.ready_o = 1'b1;
    step();
    chk("t3_b2",       32'(bus4.dat_o),   32'hB002);
    chk("t3_ready_up", 32'(bus4.ready_i), 32'h2);
    step();
    req4(1, 1'b1, 16'hB004, 1'b0);
    chk("t3_b3", 32'(bus4.dat_o), 32'hB003);
    step();
    req4(1, 1'b1, 16'hB005, 1'b1);
    chk("t3_b4", 32'(bus4.dat_o), 32'hB004);
    step();
    req4(1, 1'b0, 16'h0, 1'b0);
    chk("t3_b5",     32'(bus4.dat_o), 32'hB005);
    chk("t3_b5_eop", 32'(bus4.eop_o), 32'd1);
    step();
    chk("t3_idle", 32'(bus4.valid_o), 32'd0);

    // requester 1 drops valid mid-packet while requester 3 waits
    req4(1, 1'b1, 16'hC001, 1'b0);
    step();
    chk("t5_gnt", 32'(bus4.gnt_o), 32'h2);
    step();
    req4(1, 1'b0, 16'hC0FF, 1'b0);
    req4(3, 1'b1, 16'hD001, 1'b1);
    chk("t5_c1", 32'(bus4.dat_o), 32'hC001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_gnt", 32'(bus4.gnt_o),   32'h2);
      chk("t5_hold_rdy", 32'(bus4.ready_i), 32'h2);
      chk("t5_no_beat",  32'(bus4.valid_o), 32'd0);
    end
    req4(1, 1'b1, 16'hC002, 1'b1);
    step();
    req4(1, 1'b0, 16'h0, 1'b0);
    chk("t5_c2",     32'(bus4.dat_o), 32'hC002);
    chk("t5_c2_src", 32'(bus4.src_o), 32'd1);
    step();
    chk("t5_gnt3", 32'(bus4.gnt_o), 32'h8);
    step();
    req4(3, 1'b0, 16'h0, 1'b0);
    chk("t5_d1",     32'(bus4.dat_o), 32'hD001);
    chk("t5_d1_src", 32'(bus4.src_o), 32'd3);
    step();

    // three-requester instance: pointer wraps from 2 to 0
    req3(2, 1'b1, 16'h3002, 1'b1);
    step();
    chk("t4_gnt2", 32'(bus3.gnt_o), 32'h4);
    step();
    req3(2, 1'b1, 16'h3022, 1'b1);
    req3(0, 1'b1, 16'h3000, 1'b1);
    chk("t4_src2", 32'(bus3.src_o), 32'd2);
    chk("t4_dat2", 32'(bus3.dat_o), 32'h3002);
    chk("t4_ptr",  32'(dut3.ptr_q), 32'd0);
    step();
    chk("t4_gnt0", 32'(bus3.gnt_o), 32'h1);
    step();
    req3(0, 1'b0, 16'h0, 1'b0);
    req3(2, 1'b0, 16'h0, 1'b0);
    chk("t4_dat0", 32'(bus3.dat_o), 32'h3000);
    chk("t4_src0", 32'(bus3.src_o), 32'd0);
    step();

    // move ptr to 2, then reset mid-packet with the backup entry full
    req4(1, 1'b1, 16'h0C0C, 1'b1);
    step();
    step();
    req4(1, 1'b0, 16'h0, 1'b0);
    chk("t6_pre_src", 32'(bus4.src_o), 32'd1);
    step();
    req4(3, 1'b1, 16'hE001, 1'b0);
    step();
    chk("t6_gnt", 32'(bus4.gnt_o), 32'h8);
    step();
    bus4.ready_o = 1'b0;
    req4(3, 1'b1, 16'hE002, 1'b0);
    step();
    chk("t6_full", 32'(bus4.ready_i), 32'd0);
    arst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus4.valid_o), 32'd0);
    chk("t6_dat",   32'(bus4.dat_o),   32'd0);
    chk("t6_eop",   32'(bus4.eop_o),   32'd0);
    chk("t6_src",   32'(bus4.src_o),   32'd0);
    chk("t6_gnt0",  32'(bus4.gnt_o),   32'd0);
    chk("t6_ready", 32'(bus4.ready_i), 32'd0);
    chk("t6_state", 32'(dut.state_q),  32'(ARB_IDLE));
    chk("t6_ptr",   32'(dut.ptr_q),    32'd0);
    step();
    chk("t6_valid_hold", 32'(bus4.valid_o), 32'd0);
    req4(3, 1'b0, 16'h0, 1'b0);
    bus4.ready_o = 1'b1;
    arst_n = 1'b1;
    req4(1, 1'b1, 16'h5001, 1'b1);
    req4(3, 1'b1, 16'h5003, 1'b1);
    step();
    chk("t6_post_gnt", 32'(bus4.gnt_o), 32'h2);
    step();
    req4(1, 1'b0, 16'h0, 1'b0);
    req4(3, 1'b0, 16'h0, 1'b0);
    chk("t6_post_dat", 32'(bus4.dat_o), 32'h5001);
    chk("t6_post_src", 32'(bus4.src_o), 32'd1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
